// File: rtl/score_display_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_display_pkg : 7-segment patterns and BCD helpers          (rev 1.0)
// ---------------------------------------------------------------------------
package score_display_pkg;

  localparam logic [3:0] BCD_NINE  = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit : one BCD counter cell with ripple carry/borrow       (rev 1.0)
// ---------------------------------------------------------------------------
module bcd_digit
  import score_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       up,
  input  logic       down,
  input  logic       cin,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       borrow_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (cin) begin
      if (up) begin
        q <= (q == BCD_NINE) ? 4'd0 : q + 4'd1;
      end else if (down) begin
        q <= (q == 4'd0) ? BCD_NINE : q - 4'd1;
      end
    end
  end

  assign carry_out  = cin & up & (q == BCD_NINE);
  assign borrow_out = cin & down & (q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_display : BCD score/high-score with multiplexed 7-seg scan (rev 1.0)
// ---------------------------------------------------------------------------
module score_display
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_SCANS = 64,
  parameter int SATURATE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    ena,
  input  logic                    invert,
  input  logic                    lz_blank,
  input  logic                    blink,
  input  logic                    show_high,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digits,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    overflow
);

  localparam int   PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   IW  = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
  localparam int   BW  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic SAT = (SATURATE != 0);

  logic                    w_up, w_down, w_step;
  logic                    w_all_nines, w_all_zero;
  logic [NUM_DIGITS:0]     w_chain;
  logic [NUM_DIGITS-1:0]   w_carry, w_borrow;
  logic                    w_overflow;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_phase;
  logic                    w_presc_tc, w_scan_wrap;

  logic [4*NUM_DIGITS-1:0] w_disp;
  logic [3:0]              w_val;
  logic                    w_upper_zero, w_lead_zero, w_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg;

  always_comb begin
    w_all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_all_nines = w_all_nines & (score_bcd[4*i +: 4] == BCD_NINE);
    end
    w_all_zero = (score_bcd == '0);
  end

  // Saturate and floor are resolved here by suppressing the whole step.
  assign w_up   = inc & ~dec;
  assign w_down = dec & ~inc;
  assign w_step = ~clr & ((w_up & ~(SAT & w_all_nines)) | (w_down & ~w_all_zero));

  assign w_chain[0] = w_step;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .up         (w_up),
      .down       (w_down),
      .cin        (w_chain[i]),
      .q          (score_bcd[4*i +: 4]),
      .carry_out  (w_carry[i]),
      .borrow_out (w_borrow[i])
    );
    assign w_chain[i+1] = w_carry[i] | w_borrow[i];
  end

  // When wrapping, the ripple carry out of the top digit is the overflow.
  assign w_overflow = SAT ? (~clr & w_up & w_all_nines) : w_chain[NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      high_bcd <= '0;
    end else begin
      overflow <= w_overflow;
      if (score_bcd > high_bcd) high_bcd <= score_bcd;
    end
  end

  assign w_presc_tc  = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_scan_wrap = w_presc_tc & (r_idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_presc <= w_presc_tc ? '0 : r_presc + PW'(1);
      if (w_presc_tc) r_idx <= w_scan_wrap ? '0 : r_idx + IW'(1);
      if (w_scan_wrap) begin
        if (r_blink_cnt == BW'(BLINK_SCANS - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    w_disp       = show_high ? high_bcd : score_bcd;
    w_val        = 4'd0;
    w_lead_zero  = 1'b0;
    w_onehot     = '0;
    w_upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero & (w_disp[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_val       = w_disp[4*i +: 4];
        w_lead_zero = w_upper_zero & (i != 0);
        w_onehot[i] = 1'b1;
      end
    end
    w_blank = ~ena | (blink & r_blink_phase) | (lz_blank & w_lead_zero);
    w_seg   = w_blank ? SEG_BLANK : seg7_encode(w_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments <= 7'h00;
      digits   <= '0;
    end else begin
      segments <= invert ? ~w_seg : w_seg;
      digits   <= invert ? ~w_onehot : w_onehot;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_score_display : directed checks of counter, high score, scan and blink
// ---------------------------------------------------------------------------
module tb_score_display;

  logic clk = 1'b0;
  logic rst_n;
  logic ena, invert, lz_blank, show_high;
  logic inc0, dec0, clr0, inc1, dec1, clr1, inc2;

  logic [6:0] seg0, seg1, seg2, seg3;
  logic [1:0] dig0, dig1, dig3;
  logic [2:0] dig2;
  logic [7:0] score0, high0, score1, high1, score3, high3;
  logic [11:0] score2, high2;
  logic ovf0, ovf1, ovf2, ovf3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_display #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLINK_SCANS(64), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .inc(inc0), .dec(dec0), .ena(ena),
    .invert(invert), .lz_blank(lz_blank), .blink(1'b0), .show_high(show_high),
    .segments(seg0), .digits(dig0), .score_bcd(score0), .high_bcd(high0), .overflow(ovf0));

  score_display #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLINK_SCANS(64), .SATURATE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .inc(inc1), .dec(dec1), .ena(ena),
    .invert(invert), .lz_blank(lz_blank), .blink(1'b0), .show_high(show_high),
    .segments(seg1), .digits(dig1), .score_bcd(score1), .high_bcd(high1), .overflow(ovf1));

  score_display #(.NUM_DIGITS(3), .REFRESH_DIV(4), .BLINK_SCANS(64), .SATURATE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(inc2), .dec(1'b0), .ena(ena),
    .invert(invert), .lz_blank(lz_blank), .blink(1'b0), .show_high(show_high),
    .segments(seg2), .digits(dig2), .score_bcd(score2), .high_bcd(high2), .overflow(ovf2));

  score_display #(.NUM_DIGITS(2), .REFRESH_DIV(1), .BLINK_SCANS(2), .SATURATE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(1'b0), .dec(1'b0), .ena(1'b1),
    .invert(1'b0), .lz_blank(1'b0), .blink(1'b1), .show_high(1'b0),
    .segments(seg3), .digits(dig3), .score_bcd(score3), .high_bcd(high3), .overflow(ovf3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until u2's digit select moves from last_pat to first_pat.
  task automatic sync_scan(input logic [2:0] last_pat, input logic [2:0] first_pat);
    logic [2:0] prev;
    bit found;
    prev  = dig2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (prev == last_pat && dig2 == first_pat) found = 1'b1;
      prev = dig2;
    end
    check_eq("scan_sync", {31'b0, found}, 32'd1);
  endtask

  initial begin
    logic [2:0] exp_d;
    rst_n = 1'b0;
    ena = 1'b1; invert = 1'b0; lz_blank = 1'b1; show_high = 1'b0;
    inc0 = 1'b0; dec0 = 1'b0; clr0 = 1'b0;
    inc1 = 1'b0; dec1 = 1'b0; clr1 = 1'b0; inc2 = 1'b0;
    repeat (3) step();

    check_eq("rst_score", 32'(score0), 32'h00);
    check_eq("rst_high",  32'(high0),  32'h00);
    check_eq("rst_ovf",   32'(ovf0),   32'h0);
    check_eq("rst_seg",   32'(seg3),   32'h00);
    check_eq("rst_dig",   32'(dig3),   32'h0);

    // Blink: lit 4 cycles, blank 4 cycles, digits toggling every cycle.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_eq("blink_seg", 32'(seg3), (((k - 1) / 4) % 2 == 0) ? 32'h3F : 32'h00);
      check_eq("blink_dig", 32'(dig3), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
    end

    // clr + inc together on 47.
    inc0 = 1'b1;
    repeat (47) step();
    inc0 = 1'b0;
    step();
    check_eq("s47_score", 32'(score0), 32'h47);
    check_eq("s47_high",  32'(high0),  32'h47);
    clr0 = 1'b1; inc0 = 1'b1;
    step();
    check_eq("clrinc_score", 32'(score0), 32'h00);
    check_eq("clrinc_ovf",   32'(ovf0),   32'h0);
    clr0 = 1'b0; inc0 = 1'b0;
    step();
    check_eq("clrinc_high", 32'(high0), 32'h47);

    // 99 increments on both wrap and saturate instances.
    inc0 = 1'b1; inc1 = 1'b1;
    repeat (99) step();
    check_eq("w99_score", 32'(score0), 32'h99);
    check_eq("w99_ovf",   32'(ovf0),   32'h0);
    check_eq("s99_score", 32'(score1), 32'h99);
    step();
    check_eq("wrap_score", 32'(score0), 32'h00);
    check_eq("wrap_ovf",   32'(ovf0),   32'h1);
    check_eq("wrap_high",  32'(high0),  32'h99);
    check_eq("sat_score",  32'(score1), 32'h99);
    check_eq("sat_ovf",    32'(ovf1),   32'h1);
    inc0 = 1'b0; inc1 = 1'b0;
    step();
    check_eq("wrap_ovf_end", 32'(ovf0), 32'h0);
    check_eq("sat_ovf_end",  32'(ovf1), 32'h0);
    check_eq("wrap_high2",   32'(high0), 32'h99);

    // Floor, inc+dec no-op, borrow.
    clr1 = 1'b1;
    step();
    clr1 = 1'b0; dec1 = 1'b1;
    step();
    check_eq("floor_score", 32'(score1), 32'h00);
    dec1 = 1'b0; inc1 = 1'b1;
    repeat (42) step();
    dec1 = 1'b1;
    step();
    check_eq("incdec_score", 32'(score1), 32'h42);
    inc1 = 1'b0;
    repeat (3) step();
    check_eq("borrow_score", 32'(score1), 32'h39);
    dec1 = 1'b0;

    // Scan of 005 with leading-zero blanking.
    inc2 = 1'b1;
    repeat (5) step();
    inc2 = 1'b0;
    check_eq("scan_score", 32'(score2), 32'h005);
    sync_scan(3'b100, 3'b001);
    for (int j = 0; j < 12; j++) begin
      exp_d = 3'b001 << (j / 4);
      check_eq("scan_dig", 32'(dig2), 32'(exp_d));
      check_eq("scan_seg", 32'(seg2), (j < 4) ? 32'h6D : 32'h00);
      step();
    end

    // Inverted and disabled: all segments off (high), digits still scan.
    invert = 1'b1; ena = 1'b0;
    sync_scan(3'b011, 3'b110);
    for (int j = 0; j < 8; j++) begin
      exp_d = ~(3'b001 << (j / 4));
      check_eq("inv_dig", 32'(dig2), 32'(exp_d));
      check_eq("inv_seg", 32'(seg2), 32'h7F);
      step();
    end

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_seg3",  32'(seg3),   32'h00);
    check_eq("arst_dig3",  32'(dig3),   32'h0);
    check_eq("arst_dig2",  32'(dig2),   32'h0);
    check_eq("arst_score", 32'(score1), 32'h00);
    check_eq("arst_high",  32'(high0),  32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_display.md
# score_display

Parametrised successor to the two-digit game score display. It combines an N-digit BCD score counter with increment, decrement and clear, and keeps a high-score register. It time-multiplexes a common-anode or common-cathode 7-segment display at a programmable refresh rate, with leading-zero blanking and blink. It sits beside the game controller, which drives `inc`/`clr`/`ena`, and feeds the board segment/digit pins directly.

## Interface

**Parameters**
- `NUM_DIGITS`, default 2: number of BCD digits and display digits, legal 1..8.
- `REFRESH_DIV`, default 50000: clk cycles per digit scan slot, minimum 1.
- `BLINK_SCANS`, default 64: full scans per blink half-period, minimum 1.
- `SATURATE`, default 0: 0 = wrap to all-zero past max; 1 = hold at all-nines.

**Ports**
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clr`, in, 1: synchronous score clear; does not clear the high score.
- `inc`, in, 1: single-cycle score increment request.
- `dec`, in, 1: single-cycle score decrement request.
- `ena`, in, 1: display enable; 0 blanks all segments while scanning continues.
- `invert`, in, 1: 1 = active-low segment and digit outputs (common anode).
- `lz_blank`, in, 1: leading-zero blanking enable.
- `blink`, in, 1: blink the whole display.
- `show_high`, in, 1: display the high score instead of the score.
- `segments`, out, 7: {g,f,e,d,c,b,a}, registered.
- `digits`, out, NUM_DIGITS: one-hot digit select, registered; bit 0 is the least significant digit.
- `score_bcd`, out, 4*NUM_DIGITS: current score, packed BCD.
- `high_bcd`, out, 4*NUM_DIGITS: high score, packed BCD.
- `overflow`, out, 1: one-cycle pulse when `inc` is applied at all-nines.

## Operation

**Counter update.** Priority is `clr` > (`inc` xor `dec`). If `inc` and `dec` are both high, the score does not change.
- `inc`: BCD ripple increment. A digit at 9 becomes 0 and carries into the next digit.
- At all-nines:
  - `inc` pulses `overflow`.
  - Score becomes all-zero if SATURATE=0.
  - Score is unchanged if SATURATE=1.
- `dec`: BCD borrow decrement. At zero the score stays zero (floor); there is no flag.
- `clr` together with `inc` clears the score and does not pulse `overflow`.

**High score.** Each cycle where `score_bcd` > `high_bcd` (BCD compare, most significant digit first), `high_bcd` <= `score_bcd`. It is cleared only by reset.

**Scan.**
- The prescaler counts 0..REFRESH_DIV-1. At terminal count, the scan index advances 0..NUM_DIGITS-1 and wraps.
- Each wrap of the scan index advances the blink scan counter. At BLINK_SCANS wraps it toggles `blink_phase` and restarts.

**Digit blanking.** The selected digit value is v = (`show_high` ? `high_bcd` : `score_bcd`)[idx]. The digit is blank if any of the following holds:
- `ena` = 0;
- `blink` = 1 and `blink_phase` = 1;
- `lz_blank` = 1, idx != 0, and all digits at index idx and above are zero.

Digit 0 is never blanked by leading-zero blanking.

**Output encoding.**
- Segments use the standard 0-9 encoding; blank is all segments off.
- `digits` = one-hot(idx). When `invert` = 1, both `segments` and `digits` are bitwise inverted.
- BCD values above 9 cannot occur; the encoder maps them to blank.

## Timing

**Reset values (`rst_n` = 0).**
- `score_bcd` = 0, `high_bcd` = 0, `overflow` = 0.
- `segments` = 0, `digits` = 0.
- Prescaler, scan index, blink counter and `blink_phase` all = 0.

**Latency.**
- `inc`/`dec`/`clr` to `score_bcd`: 1 cycle.
- `score_bcd` to `high_bcd`: 1 additional cycle.
- `overflow`: asserted in the same cycle the score register updates.
- `segments`/`digits`: registered every cycle from the current idx and values, so an input change appears 1 cycle later.
- `invert`, `ena`, `blink`, `lz_blank`, `show_high`: take effect 1 cycle after the change.

**Reset behaviour.**
- `rst_n` deasserting mid-scan restarts at idx 0 with a full REFRESH_DIV slot.
- With `invert` = 1, the first cycle after reset drives all-lit patterns; these are corrected on the next clock.

**Edge parameter values.**
- NUM_DIGITS = 1: idx is constant 0 and `digits` is constantly active.
- REFRESH_DIV = 1: idx advances every cycle.

## Structure

**Shared package** `score_display_pkg`:
- 7-bit segment patterns for 0-9;
- `SEG_BLANK`;
- the function `seg7_encode(bcd)`;
- the `BCD_NINE` constant.

**Sub-module** `bcd_digit`: one digit cell.
- Inputs: `clr`, `up`, `down`, `cin`.
- Outputs: `q`, `carry_out` (at 9 and up), `borrow_out` (at 0 and down).
- Instantiate NUM_DIGITS copies with a generate loop.
- The saturate/floor decision is made at the top using the all-nines/all-zero detect.

## Test plan

1. NUM_DIGITS=2, SATURATE=0: 99 `inc` pulses, then 1 more -> `score_bcd` 0x99 then 0x00, `overflow` high exactly 1 cycle, `high_bcd` = 0x99.
2. SATURATE=1: at 0x99 `inc` -> score holds 0x99 and `overflow` pulses. At 0x00 `dec` -> score holds 0x00. `inc`+`dec` together at 0x42 -> 0x42.
3. Score 0x47, `clr`+`inc` same cycle -> score 0x00, no `overflow`, `high_bcd` stays 0x47.
4. REFRESH_DIV=4, NUM_DIGITS=3, score 0x005, `lz_blank`=1, `invert`=0 -> `digits` cycles 001/010/100 every 4 cycles; `segments` = 0x6D on idx 0 and 0x00 on idx 1 and 2.
5. `invert`=1, `ena`=0 -> `segments` = 7'h7F, and `digits` keeps scanning inverted.
6. `blink`=1, BLINK_SCANS=2, REFRESH_DIV=1, NUM_DIGITS=2 -> display alternates lit/blank every 4 cycles. Asserting `rst_n`=0 mid-pattern zeroes all outputs immediately, without a clock.
